fetch_stage: RTL

- PC register, instruction-memory fetch sequencer and IF/ID pipeline register of the 5-stage RISC-V core.
- Consumes the load-use `stall`/`pc_write` pair from the hazard unit: holds PC and IF/ID while stalled, refills when released.
- Applies EX-stage redirects (branch/jump) by flushing IF/ID and discarding any in-flight fetch.
- Talks to instruction memory over a single-outstanding request/response interface with variable latency.

---
 rtl/fetch_stage_if.sv | 31 +++
 rtl/fetch_stage.sv | 123 ++++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_if
// Description : Instruction-memory request/response bundle between the fetch
//               stage (master) and instruction memory (slave). One request
//               may be outstanding; each request gets exactly one response.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : PC register, single-outstanding instruction fetch sequencer
//               and IF/ID pipeline register. Honours load-use stalls through a
//               one-entry skid buffer and squashes in-flight fetches on EX
//               redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            pc_write,
  input  wire logic            stall,
  input  wire logic            redirect_valid,
  input  wire logic [XLEN-1:0] redirect_pc,
  fetch_stage_if.master        imem,
  output logic                 if_id_valid,
  output logic [XLEN-1:0]      if_id_pc,
  output logic [31:0]          if_id_instr
);

  // FETCH: idle, WAIT: response will be used, DROP: response will be discarded
  localparam logic [1:0] c_FETCH = 2'd0;
  localparam logic [1:0] c_WAIT  = 2'd1;
  localparam logic [1:0] c_DROP  = 2'd2;

  localparam logic [XLEN-1:0] c_PC_STEP = XLEN'(4);

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_pc;     // address of the outstanding request (response tag)
  logic            r_buf_valid;
  logic [XLEN-1:0] r_buf_pc;
  logic [31:0]     r_buf_instr;
  logic            r_if_id_valid;
  logic [XLEN-1:0] r_if_id_pc;
  logic [31:0]     r_if_id_instr;

  logic w_issue;
  logic w_resp_use;

  // A request issues only when idle, enabled, the skid buffer is empty and
  // no redirect is landing this cycle; reset masks it immediately.
  assign w_issue    = (r_state == c_FETCH) && pc_write && !r_buf_valid &&
                      !redirect_valid && !rst;
  // A response that will actually be delivered to IF/ID or the skid buffer.
  assign w_resp_use = (r_state == c_WAIT) && imem.imem_rvalid && !redirect_valid;

  assign imem.imem_req  = w_issue;
  assign imem.imem_addr = r_pc;

  assign if_id_valid = r_if_id_valid;
  assign if_id_pc    = r_if_id_pc;
  assign if_id_instr = r_if_id_instr;

  // PC, request tag and fetch-sequencer state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
      r_state  <= c_FETCH;
    end else if (redirect_valid) begin
      r_pc <= redirect_pc;
      case (r_state)
        // Outstanding response still to come must be swallowed.
        c_WAIT:  r_state <= imem.imem_rvalid ? c_FETCH : c_DROP;
        // If the stale response lands in this very cycle it is consumed here,
        // otherwise keep waiting for it.
        c_DROP:  r_state <= imem.imem_rvalid ? c_FETCH : c_DROP;
        default: r_state <= c_FETCH;
      endcase
    end else if (w_issue) begin
      r_pc     <= r_pc + c_PC_STEP;
      r_req_pc <= r_pc;
      r_state  <= c_WAIT;
    end else if (imem.imem_rvalid && (r_state != c_FETCH)) begin
      r_state <= c_FETCH;
    end
  end

  // IF/ID register and one-entry skid buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_valid   <= 1'b0;
      r_buf_pc      <= '0;
      r_buf_instr   <= NOP_INSTR;
      r_if_id_valid <= 1'b0;
      r_if_id_pc    <= '0;
      r_if_id_instr <= NOP_INSTR;
    end else if (redirect_valid) begin
      // Flush wins over stall; the PC field is left as is.
      r_buf_valid   <= 1'b0;
      r_if_id_valid <= 1'b0;
      r_if_id_instr <= NOP_INSTR;
    end else if (!stall) begin
      if (r_buf_valid) begin
        r_buf_valid   <= 1'b0;
        r_if_id_valid <= 1'b1;
        r_if_id_pc    <= r_buf_pc;
        r_if_id_instr <= r_buf_instr;
      end else if (w_resp_use) begin
        r_if_id_valid <= 1'b1;
        r_if_id_pc    <= r_req_pc;
        r_if_id_instr <= imem.imem_rdata;
      end else begin
        r_if_id_valid <= 1'b0;
        r_if_id_instr <= NOP_INSTR;
      end
    end else if (w_resp_use) begin
      // IF/ID holds; park the arriving instruction until the stall releases.
      r_buf_valid <= 1'b1;
      r_buf_pc    <= r_req_pc;
      r_buf_instr <= imem.imem_rdata;
    end
  end

endmodule
`default_nettype wire
